// File: rtl/cfu_types.sv
// Shared AXI encodings and FSM state types for the
// vector-unit axi64 scratchpad slave.
package cfu_types;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  function automatic logic [1:0] axi_resp(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/vfu_sdp_ram.sv
// Simple dual-port 64-bit RAM: byte-enabled write port and
// registered read port; a same-address collision reads old data.
module vfu_sdp_ram #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic [7:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [63:0]                    wdata,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [63:0]                    rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vfu_axi64_scratchpad.sv
// AXI4 64-bit slave scratchpad terminating the vector unit's
// axi64 master; independent read and write burst engines.
module vfu_axi64_scratchpad
  import cfu_types::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ID_WIDTH    = 6,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic [3:0]            arcache,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [63:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic [3:0]            awcache,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [63:0]           wdata,
  input  logic [7:0]            wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int IW = $clog2(DEPTH_WORDS);

  function automatic logic [IW-1:0] step(
    input logic [IW-1:0] i,
    input logic          fixed
  );
    return fixed ? i : i + IW'(1);
  endfunction

  rd_state_e     r_state;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_left;
  logic          r_fixed;

  wr_state_e     w_state;
  logic [IW-1:0] w_idx;
  logic [7:0]    w_left;
  logic          w_fixed;
  logic          w_err;

  logic          ram_re;
  logic [IW-1:0] ram_raddr;
  logic [7:0]    ram_we;
  logic [63:0]   ram_q;

  logic ar_fire, r_fire, r_load;
  logic aw_fire, w_fire, w_bad;
  logic unused_bits;

  assign unused_bits = ^{araddr, awaddr, arcache, awcache};

  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;
  // r_left counts beats not yet fetched; the first is fetched at AR.
  assign r_load  = (r_state == R_BURST) && (!rvalid || rready)
                && (r_left != 8'd0);

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign w_bad   = wlast != (w_left == 8'd0);

  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = r_idx;
    unique case (1'b1)
      ar_fire: begin
        ram_re    = 1'b1;
        ram_raddr = araddr[3 +: IW];
      end
      r_load:  ram_re = 1'b1;
      default: ;
    endcase
  end

  assign ram_we = w_fire ? wstrb : 8'h00;
  assign rdata  = rvalid ? ram_q : 64'd0;

  vfu_sdp_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(w_idx),
    .wdata(wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_left  <= '0;
      r_fixed <= 1'b0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rresp   <= AXI_RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            r_state <= R_BURST;
            arready <= 1'b0;
            rid     <= arid;
            rresp   <= axi_resp(arsize != AXI_SIZE_8B);
            r_fixed <= arburst == AXI_BURST_FIXED;
            r_left  <= arlen;
            r_idx   <= step(araddr[3 +: IW],
                            arburst == AXI_BURST_FIXED);
            rvalid  <= 1'b1;
            rlast   <= arlen == 8'd0;
          end
        end
        R_BURST: begin
          if (r_fire && rlast) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
          end else if (r_load) begin
            rvalid <= 1'b1;
            rlast  <= r_left == 8'd1;
            r_left <= r_left - 8'd1;
            r_idx  <= step(r_idx, r_fixed);
          end else if (r_fire) begin
            rvalid <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_left  <= '0;
      w_fixed <= 1'b0;
      w_err   <= 1'b0;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= AXI_RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            w_state <= W_DATA;
            awready <= 1'b0;
            wready  <= 1'b1;
            bid     <= awid;
            w_idx   <= awaddr[3 +: IW];
            w_left  <= awlen;
            w_fixed <= awburst == AXI_BURST_FIXED;
            w_err   <= awsize != AXI_SIZE_8B;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_left == 8'd0) begin
              w_state <= W_RESP;
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= axi_resp(w_err || w_bad);
            end else begin
              w_left <= w_left - 8'd1;
              w_idx  <= step(w_idx, w_fixed);
              w_err  <= w_err || w_bad;
            end
          end
        end
        W_RESP: begin
          if (bvalid && bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vfu_axi64_scratchpad.sv
// Scoreboard bench for vfu_axi64_scratchpad against a word-array
// memory model; directed cases plus randomized bursts.
module tb_vfu_axi64_scratchpad;

  localparam int DEPTH = 4096;
  localparam logic [1:0] FIX = 2'b00;
  localparam logic [1:0] INC = 2'b01;
  localparam logic [1:0] WRP = 2'b10;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLV  = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0]  arid = '0, awid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0;
  logic [7:0]  arlen = '0, awlen = '0, wstrb = '0;
  logic [2:0]  arsize = '0, awsize = '0;
  logic [1:0]  arburst = '0, awburst = '0, rresp, bresp;
  logic [3:0]  arcache = '0, awcache = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
  logic        wlast = 1'b0;
  logic        arready, awready, wready, rvalid, rlast, bvalid;
  logic        rready = 1'b0, bready = 1'b0;
  logic [63:0] rdata, wdata = '0;

  always #5 clk = ~clk;

  vfu_axi64_scratchpad #(
    .DEPTH_WORDS(DEPTH), .ID_WIDTH(6), .ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arcache(arcache),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awcache(awcache),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [5:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [63:0] model [DEPTH];
  int checks = 0, failures = 0, r_pops = 0, b_pops = 0;
  int rmode = 0, bmode = 0, pi = 0;
  logic [3:0] rpat = 4'b1001;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: rready = 1'b1;
      1: rready = $urandom_range(0, 3) != 0;
      default: begin
        rready = rpat[pi];
        pi = (pi + 1) % 4;
      end
    endcase
    bready = bmode != 0 ? $urandom_range(0, 1) == 1 : 1'b1;
  end

  logic        hold_prev = 1'b0, hold_last = 1'b0;
  logic [63:0] hold_data = '0;

  always @(negedge clk) begin
    rbeat_t e;
    bexp_t  b;
    if (hold_prev && !rst) begin
      chk("r_stall_valid", 64'(rvalid), 64'd1);
      chk("r_stall_data", rdata, hold_data);
      chk("r_stall_last", 64'(rlast), 64'(hold_last));
    end
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL r_unexpected: got beat %h expected none", rdata);
      end else begin
        e = rq.pop_front();
        chk("rid", 64'(rid), 64'(e.id));
        chk("rdata", rdata, e.data);
        chk("rresp", 64'(rresp), 64'(e.resp));
        chk("rlast", 64'(rlast), 64'(e.last));
        r_pops++;
      end
    end
    hold_prev = !rst && rvalid && !rready;
    hold_data = rdata;
    hold_last = rlast;
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected: got bid %h expected none", bid);
      end else begin
        b = bq.pop_front();
        chk("bid", 64'(bid), 64'(b.id));
        chk("bresp", 64'(bresp), 64'(b.resp));
        b_pops++;
      end
    end
  end

  task automatic hs(input int ch, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = ch == 0 ? arready : (ch == 1 ? awready : wready);
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_write(input logic [5:0] id, input logic [31:0] addr,
                          input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [63:0] dq[$],
                          input logic [7:0] sq[$], input int bad,
                          input bit gaps);
    int  idx = int'((addr >> 3) % DEPTH);
    bit  err = size != 3'd3;
    bit  ok;
    int  n = 0;
    int  tgt;
    for (int i = 0; i <= len; i++) begin
      for (int b = 0; b < 8; b++)
        if (sq[i][b]) model[idx][8*b +: 8] = dq[i][8*b +: 8];
      if (bad >= 0 && ((i == bad) != (i == len))) err = 1'b1;
      if (burst != FIX) idx = (idx + 1) % DEPTH;
    end
    bq.push_back('{id, err ? SLV : OKAY});
    tgt = b_pops + 1;
    awid = id; awaddr = addr; awlen = len[7:0]; awsize = size;
    awburst = burst; awcache = 4'($urandom); awvalid = 1'b1;
    hs(1, ok);
    awvalid = 1'b0;
    chk("aw_timeout", 64'(ok), 64'd1);
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      wdata = dq[i]; wstrb = sq[i];
      wlast = bad >= 0 ? i == bad : i == len;
      wvalid = 1'b1;
      hs(2, ok);
      wvalid = 1'b0;
      chk("w_timeout", 64'(ok), 64'd1);
    end
    while (b_pops < tgt && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("b_timeout", 64'(b_pops >= tgt), 64'd1);
  endtask

  task automatic do_read(input logic [5:0] id, input logic [31:0] addr,
                         input int len, input logic [2:0] size,
                         input logic [1:0] burst, input bit lat,
                         input bit drain);
    int idx = int'((addr >> 3) % DEPTH);
    bit ok;
    int n = 0;
    for (int i = 0; i <= len; i++) begin
      rq.push_back('{id, model[idx], size != 3'd3 ? SLV : OKAY, i == len});
      if (burst != FIX) idx = (idx + 1) % DEPTH;
    end
    arid = id; araddr = addr; arlen = len[7:0]; arsize = size;
    arburst = burst; arcache = 4'($urandom); arvalid = 1'b1;
    hs(0, ok);
    arvalid = 1'b0;
    chk("ar_timeout", 64'(ok), 64'd1);
    if (lat) chk("r_first_latency", 64'(rvalid), 64'd1);
    if (drain) begin
      while (rq.size() != 0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      chk("r_drain_timeout", 64'(rq.size()), 64'd0);
    end
  endtask

  task automatic one_write(input logic [31:0] addr, input logic [63:0] d,
                           input logic [7:0] s);
    logic [63:0] dq[$];
    logic [7:0]  sq[$];
    dq.push_back(d);
    sq.push_back(s);
    do_write(6'h01, addr, 0, 3'd3, INC, dq, sq, -1, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] dq[$];
    logic [7:0]  sq[$];
    bit ok;
    int base, n, len, bad;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rid", 64'(rid), 64'd0);
    chk("rst_bid", 64'(bid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < DEPTH / 256; k++) begin
      dq.delete(); sq.delete();
      for (int j = 0; j < 256; j++) begin
        dq.push_back({$urandom, $urandom});
        sq.push_back(8'hFF);
      end
      do_write(6'(k), 32'(k * 2048), 255, 3'd3, INC, dq, sq, -1, 1'b0);
    end

    dq = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    sq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_write(6'h0A, 32'h100, 3, 3'd3, INC, dq, sq, -1, 1'b0);
    do_read(6'h15, 32'h100, 3, 3'd3, INC, 1'b1, 1'b1);

    rmode = 2;
    pi = 0;
    do_read(6'h03, 32'h100, 3, 3'd3, INC, 1'b1, 1'b1);
    rmode = 0;

    one_write(32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    one_write(32'h0, 64'h0, 8'h0F);
    do_read(6'h04, 32'h0, 0, 3'd3, INC, 1'b0, 1'b1);
    one_write(32'h0, 64'h1234_5678_9ABC_DEF0, 8'h00);
    do_read(6'h05, 32'h0, 0, 3'd3, INC, 1'b0, 1'b1);

    dq = '{64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002};
    sq = '{8'hFF, 8'hFF};
    do_write(6'h06, 32'((DEPTH - 1) * 8), 1, 3'd3, INC, dq, sq, -1, 1'b0);
    do_read(6'h07, 32'((DEPTH - 1) * 8), 0, 3'd3, INC, 1'b0, 1'b1);
    do_read(6'h08, 32'h0, 0, 3'd3, INC, 1'b0, 1'b1);
    do_read(6'h09, 32'((DEPTH - 1) * 8), 1, 3'd3, WRP, 1'b0, 1'b1);

    dq = '{64'd1, 64'd2, 64'd3};
    sq = '{8'hFF, 8'hFF, 8'hFF};
    do_write(6'h0B, 32'h2000, 2, 3'd3, FIX, dq, sq, -1, 1'b0);
    do_read(6'h0C, 32'h2000, 2, 3'd3, FIX, 1'b0, 1'b1);

    dq = '{64'hDEAD_BEEF_0000_0001};
    sq = '{8'hFF};
    do_write(6'h0D, 32'h3000, 0, 3'd2, INC, dq, sq, -1, 1'b0);
    do_read(6'h0E, 32'h3000, 0, 3'd3, INC, 1'b0, 1'b1);
    dq = '{64'h10, 64'h20, 64'h30, 64'h40};
    sq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_write(6'h0F, 32'h3100, 3, 3'd3, INC, dq, sq, 1, 1'b0);
    do_read(6'h10, 32'h3100, 3, 3'd2, INC, 1'b0, 1'b1);

    rmode = 1;
    bmode = 1;
    for (int it = 0; it < 30; it++) begin
      dq.delete(); sq.delete();
      len = $urandom_range(0, 15);
      for (int j = 0; j <= len; j++) begin
        dq.push_back({$urandom, $urandom});
        sq.push_back(8'($urandom));
      end
      bad = $urandom_range(0, 5) == 0 ? $urandom_range(0, len) : -1;
      a = $urandom;
      do_write(6'($urandom), a, len, $urandom_range(0, 7) == 0 ?
               3'($urandom) : 3'd3, 2'($urandom_range(0, 2)),
               dq, sq, bad, 1'b1);
      do_read(6'($urandom), $urandom_range(0, 3) == 0 ? a : $urandom,
              $urandom_range(0, 15), $urandom_range(0, 7) == 0 ?
              3'($urandom) : 3'd3, 2'($urandom_range(0, 2)),
              1'b1, 1'b1);
      if (it % 5 == 0) begin
        dq.delete(); sq.delete();
        for (int j = 0; j < 8; j++) begin
          dq.push_back({$urandom, $urandom});
          sq.push_back(8'hFF);
        end
        fork
          do_write(6'h21, 32'h40, 7, 3'd3, INC, dq, sq, -1, 1'b1);
          do_read(6'h22, 32'h4000, 7, 3'd3, INC, 1'b0, 1'b1);
        join
        do_read(6'h23, 32'h40, 7, 3'd3, INC, 1'b0, 1'b1);
      end
    end
    rmode = 0;
    bmode = 0;
    @(posedge clk);
    #1;

    awid = 6'h31; awaddr = 32'h300; awlen = 8'd3; awsize = 3'd3;
    awburst = INC; awvalid = 1'b1;
    hs(1, ok);
    awvalid = 1'b0;
    chk("rstm_aw", 64'(ok), 64'd1);
    wdata = 64'hC0DE_0000_0000_0060; wstrb = 8'hFF; wlast = 1'b0;
    wvalid = 1'b1;
    hs(2, ok);
    wvalid = 1'b0;
    chk("rstm_w", 64'(ok), 64'd1);
    model[32'h300 >> 3] = 64'hC0DE_0000_0000_0060;
    base = r_pops;
    do_read(6'h32, 32'h800, 7, 3'd3, INC, 1'b1, 1'b0);
    n = 0;
    while (r_pops < base + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rstm_rvalid", 64'(rvalid), 64'd0);
    chk("rstm_bvalid", 64'(bvalid), 64'd0);
    chk("rstm_wready", 64'(wready), 64'd0);
    rq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rstm_arready", 64'(arready), 64'd1);
    chk("rstm_awready", 64'(awready), 64'd1);
    dq = '{64'h61, 64'h62};
    sq = '{8'hFF, 8'hFF};
    do_write(6'h33, 32'h308, 1, 3'd3, INC, dq, sq, -1, 1'b0);
    do_read(6'h34, 32'h300, 3, 3'd3, INC, 1'b1, 1'b1);
    do_read(6'h35, 32'h800, 7, 3'd3, INC, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
